z80_alu_unit: RTL and testbench

Z80_ALU_UNIT -- requirements
Module: z80_alu_unit

---
 rtl/z80_alu_unit.sv | 154 +++++++++++++++
 tb/tb_z80_alu_unit.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/z80_alu_unit.sv
// Z80-style ALU datapath: ACT/TMP operand latches, RES/F result registers and one-cycle register-file load strobes.
// Optional build macro Z80_ALU_UNDOC_FLAGS_EN copies the undocumented Y/X flag bits; without it F[5] and F[3] stay 0.
module z80_alu_unit (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] alu_sel,
    input  logic [7:0] db_in,
    input  logic [7:0] r_sel,
    output logic [7:0] alu_out,
    output logic [7:0] ld_r,
    output logic [3:0] re_r,
    output logic [7:0] acc_io,
    output logic [7:0] flag_io
);

    typedef enum logic [3:0] {
        OP_NOP    = 4'h0,
        OP_LD_ACT = 4'h1,
        OP_LD_TMP = 4'h2,
        OP_ADD    = 4'h3,
        OP_ADC    = 4'h4,
        OP_SUB    = 4'h5,
        OP_SBC    = 4'h6,
        OP_AND    = 4'h7,
        OP_XOR    = 4'h8,
        OP_OR     = 4'h9,
        OP_CP     = 4'hA,
        OP_INC    = 4'hB,
        OP_DEC    = 4'hC,
        OP_DRIVE  = 4'hD,
        OP_NOP_E  = 4'hE,
        OP_NOP_F  = 4'hF
    } alu_op_e;

    alu_op_e    op;
    logic [7:0] act_q, act_d, tmp_q, tmp_d, res_q, res_d, f_q, f_d;
    logic       ld_a_q, ld_a_d, ld_f_q, ld_f_d;

    logic [8:0] wide;
    logic [4:0] nib;
    logic [7:0] alu_res;
    logic       cy, c_f, h_f, v_f, n_f, y_f, x_f, is_alu;

    assign op = alu_op_e'(alu_sel);

    // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latch).
    always_comb begin
        act_d   = act_q;
        tmp_d   = tmp_q;
        res_d   = res_q;
        f_d     = f_q;
        ld_a_d  = 1'b0;
        ld_f_d  = 1'b0;
        cy      = 1'b0;
        wide    = '0;
        nib     = '0;
        alu_res = '0;
        c_f     = f_q[0];
        h_f     = 1'b0;
        v_f     = 1'b0;
        n_f     = 1'b0;
        y_f     = 1'b0;
        x_f     = 1'b0;

        case (op)
            OP_LD_ACT: act_d = db_in;
            OP_LD_TMP: tmp_d = db_in;
            OP_ADD, OP_ADC: begin
                cy      = (op == OP_ADC) & f_q[0];
                wide    = {1'b0, act_q} + {1'b0, tmp_q} + {8'd0, cy};
                nib     = {1'b0, act_q[3:0]} + {1'b0, tmp_q[3:0]} + {4'd0, cy};
                alu_res = wide[7:0];
                c_f     = wide[8];
                h_f     = nib[4];
                v_f     = (act_q[7] == tmp_q[7]) && (alu_res[7] != act_q[7]);
            end
            OP_SUB, OP_SBC, OP_CP: begin
                // Zero-extended subtraction: bit 8 / bit 4 of the difference are the borrows.
                cy      = (op == OP_SBC) & f_q[0];
                wide    = {1'b0, act_q} - {1'b0, tmp_q} - {8'd0, cy};
                nib     = {1'b0, act_q[3:0]} - {1'b0, tmp_q[3:0]} - {4'd0, cy};
                alu_res = wide[7:0];
                c_f     = wide[8];
                h_f     = nib[4];
                v_f     = (act_q[7] != tmp_q[7]) && (alu_res[7] != act_q[7]);
                n_f     = 1'b1;
            end
            OP_AND, OP_XOR, OP_OR: begin
                alu_res = (op == OP_AND) ? (act_q & tmp_q) :
                          (op == OP_XOR) ? (act_q ^ tmp_q) : (act_q | tmp_q);
                h_f     = (op == OP_AND);
                c_f     = 1'b0;
                v_f     = ~^alu_res;
            end
            OP_INC: begin
                alu_res = tmp_q + 8'd1;
                h_f     = (tmp_q[3:0] == 4'hF);
                v_f     = (tmp_q == 8'h7F);
            end
            OP_DEC: begin
                alu_res = tmp_q - 8'd1;
                h_f     = (tmp_q[3:0] == 4'h0);
                v_f     = (tmp_q == 8'h80);
                n_f     = 1'b1;
            end
            default: ;
        endcase

`ifdef Z80_ALU_UNDOC_FLAGS_EN
        // CP takes Y/X from the operand rather than the discarded difference.
        y_f = (op == OP_CP) ? tmp_q[5] : alu_res[5];
        x_f = (op == OP_CP) ? tmp_q[3] : alu_res[3];
`endif

        is_alu = (op >= OP_ADD) && (op <= OP_DEC);
        if (is_alu) begin
            f_d    = {alu_res[7], (alu_res == 8'h00), y_f, h_f, x_f, v_f, n_f, c_f};
            ld_f_d = 1'b1;
            if (op != OP_CP) begin
                res_d  = alu_res;
                ld_a_d = 1'b1;
            end
        end
    end

    // NOTE: synchronous reset clears every register, including the strobe, so a reset edge cancels a pending op.
    always_ff @(posedge clk) begin
        if (!reset) begin
            act_q  <= '0;
            tmp_q  <= '0;
            res_q  <= '0;
            f_q    <= '0;
            ld_a_q <= 1'b0;
            ld_f_q <= 1'b0;
        end else begin
            act_q  <= act_d;
            tmp_q  <= tmp_d;
            res_q  <= res_d;
            f_q    <= f_d;
            ld_a_q <= ld_a_d;
            ld_f_q <= ld_f_d;
        end
    end

    logic unused_r_sel;
    assign unused_r_sel = &{1'b0, r_sel[7:4]};

    assign alu_out = (op == OP_DRIVE) ? res_q : 8'h00;
    assign re_r    = (op == OP_LD_TMP) ? r_sel[3:0] : 4'h0;
    assign ld_r    = {6'b0, ld_f_q, ld_a_q};
    assign acc_io  = res_q;
    assign flag_io = f_q;

endmodule

// File: tb/tb_z80_alu_unit.sv
// Directed bench for z80_alu_unit; flag expectations are masked to match builds with or without Z80_ALU_UNDOC_FLAGS_EN.
module tb_z80_alu_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] alu_sel;
    logic [7:0] db_in;
    logic [7:0] r_sel;
    logic [7:0] alu_out;
    logic [7:0] ld_r;
    logic [3:0] re_r;
    logic [7:0] acc_io;
    logic [7:0] flag_io;

    int total = 0;
    int bad   = 0;

`ifdef Z80_ALU_UNDOC_FLAGS_EN
    localparam logic [7:0] UNDOC_MASK = 8'hFF;
`else
    localparam logic [7:0] UNDOC_MASK = 8'hD7;
`endif

    z80_alu_unit dut (
        .clk     (clk),
        .reset   (reset),
        .alu_sel (alu_sel),
        .db_in   (db_in),
        .r_sel   (r_sel),
        .alu_out (alu_out),
        .ld_r    (ld_r),
        .re_r    (re_r),
        .acc_io  (acc_io),
        .flag_io (flag_io)
    );

    always #5 clk = ~clk;

    // Present one opcode for exactly one rising edge, then return to NOP; outputs are sampled 1ns after the edge.
    task automatic issue(input logic [3:0] op, input logic [7:0] data);
        alu_sel = op;
        db_in   = data;
        @(posedge clk);
        #1;
        alu_sel = 4'h0;
    endtask

    task automatic load(input logic [7:0] a, input logic [7:0] t);
        issue(4'h1, a);
        issue(4'h2, t);
    endtask

    task automatic test_reset;
        reset   = 1'b0;
        alu_sel = 4'h3;
        db_in   = 8'hFF;
        r_sel   = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        total++; if (acc_io !== 8'h00) begin bad++; $display("FAIL reset_acc: got %h want %h", acc_io, 8'h00); end
        total++; if (flag_io !== 8'h00) begin bad++; $display("FAIL reset_flag: got %h want %h", flag_io, 8'h00); end
        total++; if (ld_r !== 8'h00) begin bad++; $display("FAIL reset_ld_r: got %h want %h", ld_r, 8'h00); end
        total++; if (alu_out !== 8'h00) begin bad++; $display("FAIL reset_alu_out: got %h want %h", alu_out, 8'h00); end
        alu_sel = 4'h0;
        reset   = 1'b1;
        @(posedge clk);
        #1;
        total++; if (ld_r !== 8'h00) begin bad++; $display("FAIL reset_release_ld_r: got %h want %h", ld_r, 8'h00); end
    endtask

    task automatic test_add_basic;
        load(8'h33, 8'h33);
        issue(4'h3, 8'h00);
        total++; if (acc_io !== 8'h66) begin bad++; $display("FAIL add_acc: got %h want %h", acc_io, 8'h66); end
        total++; if (flag_io !== (8'h20 & UNDOC_MASK)) begin bad++; $display("FAIL add_flag: got %h want %h", flag_io, 8'h20 & UNDOC_MASK); end
        total++; if (ld_r !== 8'h03) begin bad++; $display("FAIL add_ld_r: got %h want %h", ld_r, 8'h03); end
        issue(4'h0, 8'h00);
        total++; if (ld_r !== 8'h00) begin bad++; $display("FAIL add_ld_r_one_cycle: got %h want %h", ld_r, 8'h00); end
        total++; if (acc_io !== 8'h66) begin bad++; $display("FAIL nop_hold_acc: got %h want %h", acc_io, 8'h66); end
    endtask

    task automatic test_back_to_back;
        load(8'h66, 8'h01);
        issue(4'h3, 8'h00);
        total++; if (acc_io !== 8'h67 || flag_io !== (8'h20 & UNDOC_MASK)) begin bad++; $display("FAIL b2b_add: got %h/%h want %h/%h", acc_io, flag_io, 8'h67, 8'h20 & UNDOC_MASK); end
        issue(4'h1, 8'h67);
        total++; if (ld_r !== 8'h00) begin bad++; $display("FAIL b2b_ld_after_pulse: got %h want %h", ld_r, 8'h00); end
        issue(4'h2, 8'h33);
        issue(4'h5, 8'h00);
        total++; if (acc_io !== 8'h34 || flag_io !== (8'h22 & UNDOC_MASK)) begin bad++; $display("FAIL b2b_sub: got %h/%h want %h/%h", acc_io, flag_io, 8'h34, 8'h22 & UNDOC_MASK); end
        // Two ALU ops on consecutive edges, no idle cycle between.
        load(8'h10, 8'h05);
        issue(4'h3, 8'h00);
        total++; if (acc_io !== 8'h15 || flag_io !== 8'h00) begin bad++; $display("FAIL b2b_add2: got %h/%h want %h/%h", acc_io, flag_io, 8'h15, 8'h00); end
        issue(4'h5, 8'h00);
        total++; if (acc_io !== 8'h0B || flag_io !== (8'h1A & UNDOC_MASK)) begin bad++; $display("FAIL b2b_sub2: got %h/%h want %h/%h", acc_io, flag_io, 8'h0B, 8'h1A & UNDOC_MASK); end
        total++; if (ld_r !== 8'h03) begin bad++; $display("FAIL b2b_ld_r: got %h want %h", ld_r, 8'h03); end
    endtask

    task automatic test_overflow_and;
        load(8'h7F, 8'h01);
        issue(4'h3, 8'h00);
        total++; if (acc_io !== 8'h80 || flag_io !== 8'h94) begin bad++; $display("FAIL add_overflow: got %h/%h want %h/%h", acc_io, flag_io, 8'h80, 8'h94); end
        load(8'hF0, 8'h0F);
        issue(4'h7, 8'h00);
        total++; if (acc_io !== 8'h00 || flag_io !== 8'h54) begin bad++; $display("FAIL and_zero: got %h/%h want %h/%h", acc_io, flag_io, 8'h00, 8'h54); end
    endtask

    task automatic test_cp;
        load(8'h10, 8'h20);
        issue(4'h3, 8'h00);
        total++; if (acc_io !== 8'h30) begin bad++; $display("FAIL cp_setup: got %h want %h", acc_io, 8'h30); end
        issue(4'hA, 8'h00);
        total++; if (acc_io !== 8'h30) begin bad++; $display("FAIL cp_acc_kept: got %h want %h", acc_io, 8'h30); end
        total++; if (flag_io !== (8'hA3 & UNDOC_MASK)) begin bad++; $display("FAIL cp_flag: got %h want %h", flag_io, 8'hA3 & UNDOC_MASK); end
        total++; if (ld_r !== 8'h02) begin bad++; $display("FAIL cp_ld_r: got %h want %h", ld_r, 8'h02); end
    endtask

    task automatic test_adc_sbc;
        load(8'h80, 8'h80);
        issue(4'h3, 8'h00);
        total++; if (acc_io !== 8'h00 || flag_io !== 8'h45) begin bad++; $display("FAIL add_carry: got %h/%h want %h/%h", acc_io, flag_io, 8'h00, 8'h45); end
        issue(4'h6, 8'h00);
        total++; if (acc_io !== 8'hFF || flag_io !== (8'hBB & UNDOC_MASK)) begin bad++; $display("FAIL sbc: got %h/%h want %h/%h", acc_io, flag_io, 8'hFF, 8'hBB & UNDOC_MASK); end
        issue(4'h4, 8'h00);
        total++; if (acc_io !== 8'h01 || flag_io !== 8'h05) begin bad++; $display("FAIL adc: got %h/%h want %h/%h", acc_io, flag_io, 8'h01, 8'h05); end
    endtask

    task automatic test_inc_dec;
        issue(4'h2, 8'h7F);
        issue(4'hB, 8'h00);
        total++; if (acc_io !== 8'h80 || flag_io !== 8'h95) begin bad++; $display("FAIL inc_7f: got %h/%h want %h/%h", acc_io, flag_io, 8'h80, 8'h95); end
        issue(4'h2, 8'h80);
        issue(4'hC, 8'h00);
        total++; if (acc_io !== 8'h7F || flag_io !== (8'h3F & UNDOC_MASK)) begin bad++; $display("FAIL dec_80: got %h/%h want %h/%h", acc_io, flag_io, 8'h7F, 8'h3F & UNDOC_MASK); end
        issue(4'h2, 8'hFF);
        issue(4'hB, 8'h00);
        total++; if (acc_io !== 8'h00 || flag_io !== 8'h51) begin bad++; $display("FAIL inc_wrap: got %h/%h want %h/%h", acc_io, flag_io, 8'h00, 8'h51); end
        total++; if (ld_r !== 8'h03) begin bad++; $display("FAIL inc_ld_r: got %h want %h", ld_r, 8'h03); end
    endtask

    task automatic test_logic;
        load(8'h5A, 8'h0F);
        issue(4'h8, 8'h00);
        total++; if (acc_io !== 8'h55 || flag_io !== 8'h04) begin bad++; $display("FAIL xor: got %h/%h want %h/%h", acc_io, flag_io, 8'h55, 8'h04); end
        issue(4'h9, 8'h00);
        total++; if (acc_io !== 8'h5F || flag_io !== (8'h0C & UNDOC_MASK)) begin bad++; $display("FAIL or: got %h/%h want %h/%h", acc_io, flag_io, 8'h5F, 8'h0C & UNDOC_MASK); end
    endtask

    task automatic test_drive_nop;
        alu_sel = 4'hD;
        #1;
        total++; if (alu_out !== 8'h5F) begin bad++; $display("FAIL drive_out: got %h want %h", alu_out, 8'h5F); end
        total++; if (re_r !== 4'h0) begin bad++; $display("FAIL drive_re_r: got %h want %h", re_r, 4'h0); end
        @(posedge clk);
        #1;
        total++; if (acc_io !== 8'h5F || flag_io !== (8'h0C & UNDOC_MASK) || ld_r !== 8'h00) begin bad++; $display("FAIL drive_hold: got %h/%h/%h want %h/%h/%h", acc_io, flag_io, ld_r, 8'h5F, 8'h0C & UNDOC_MASK, 8'h00); end
        issue(4'hE, 8'h00);
        total++; if (acc_io !== 8'h5F || alu_out !== 8'h00) begin bad++; $display("FAIL nop_e_hold: got %h/%h want %h/%h", acc_io, alu_out, 8'h5F, 8'h00); end
        r_sel   = 8'hA7;
        alu_sel = 4'h2;
        #1;
        total++; if (re_r !== 4'h7) begin bad++; $display("FAIL re_r_ld_tmp: got %h want %h", re_r, 4'h7); end
        alu_sel = 4'h3;
        #1;
        total++; if (re_r !== 4'h0) begin bad++; $display("FAIL re_r_other: got %h want %h", re_r, 4'h0); end
        alu_sel = 4'h0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_midop;
        load(8'h33, 8'h33);
        alu_sel = 4'h3;
        @(posedge clk);
        #1;
        alu_sel = 4'h0;
        reset   = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        total++; if (acc_io !== 8'h00 || flag_io !== 8'h00) begin bad++; $display("FAIL midop_reset_state: got %h/%h want %h/%h", acc_io, flag_io, 8'h00, 8'h00); end
        total++; if (ld_r !== 8'h00) begin bad++; $display("FAIL midop_reset_ld_r: got %h want %h", ld_r, 8'h00); end
        alu_sel = 4'hD;
        #1;
        total++; if (alu_out !== 8'h00) begin bad++; $display("FAIL midop_reset_drive: got %h want %h", alu_out, 8'h00); end
        @(posedge clk);
        #1;
        total++; if (acc_io !== 8'h00 || ld_r !== 8'h00) begin bad++; $display("FAIL midop_after_release: got %h/%h want %h/%h", acc_io, ld_r, 8'h00, 8'h00); end
        alu_sel = 4'h0;
    endtask

    initial begin
        test_reset;
        test_add_basic;
        test_back_to_back;
        test_overflow_and;
        test_cp;
        test_adc_sbc;
        test_inc_dec;
        test_logic;
        test_drive_nop;
        test_reset_midop;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
